// File: rtl/dmem_resp_pkg.sv
// Shared constants, size codes and FSM encoding for the data-memory responder.
package dmem_resp_pkg;

    localparam logic [2:0] INST_BYTE        = 3'b000;
    localparam logic [2:0] INST_HALF_WORD   = 3'b001;
    localparam logic [2:0] INST_WORD        = 3'b010;
    localparam logic [2:0] INST_BYTE_U      = 3'b100;
    localparam logic [2:0] INST_HALF_WORD_U = 3'b101;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam int          BYTE      = 8;
    localparam int          HALF_WORD = 16;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_DONE = 2'd2
    } dmem_state_e;

    function automatic logic [3:0] lane_enables(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b00:   return 4'b0001 << offset;
            2'b01:   return offset[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] size_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return {{(32 - BYTE){1'b0}}, {BYTE{1'b1}}};
            2'b01:   return {{(32 - HALF_WORD){1'b0}}, {HALF_WORD{1'b1}}};
            default: return '1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_resp_bank.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dmem_bank #(
    parameter int DEPTH = 4096,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             re_i,
    input  logic [3:0]       we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
        if (re_i) rdata_q <= mem_q[idx_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: latches a MEM-stage request, inserts wait states,
// commits stores by byte lane and returns right-aligned load data.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wmem_en_i,
    input  logic                  rmem_en_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [31:0]           mem_data_i,
    input  logic [2:0]            funct3_i,
    output logic [31:0]           rdata_o,
    output logic                  rvalid_o,
    output logic                  stall_o,
    output logic                  err_o
);

    localparam int                  IDX_W      = $clog2(DEPTH);
    localparam logic [3:0]          CNT_INIT   = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(4 * DEPTH);

    dmem_state_e           state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  store_q, store_d;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;
    logic [31:0]           rdata_q, rdata_d;

    logic                  req;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [31:0]           cur_wdata;
    logic [2:0]            cur_funct3;
    logic                  cur_store;
    logic                  cur_err;
    logic                  enter_done;
    logic [3:0]            bank_we;
    logic                  bank_re;
    logic [31:0]           bank_wdata;
    logic [31:0]           bank_rdata;

    assign req = wmem_en_i | rmem_en_i;

    // With zero wait states the RAM is accessed on the same edge the request
    // is latched, so the live inputs stand in for the latch while idle.
    always_comb begin
        if (state_q == DMEM_IDLE) begin
            cur_addr   = mem_addr_i;
            cur_wdata  = mem_data_i;
            cur_funct3 = funct3_i;
            cur_store  = wmem_en_i;
        end else begin
            cur_addr   = addr_q;
            cur_wdata  = wdata_q;
            cur_funct3 = funct3_q;
            cur_store  = store_q;
        end
    end

    always_comb begin
        cur_err = 1'b0;
        if (cur_funct3[1:0] == 2'b01 && cur_addr[0])                    cur_err = 1'b1;
        if (cur_funct3 == INST_WORD && cur_addr[1:0] != 2'b00)          cur_err = 1'b1;
        if ({1'b0, cur_addr} >= ADDR_LIMIT)                             cur_err = 1'b1;
        if (cur_store && !(cur_funct3 inside {INST_BYTE, INST_HALF_WORD, INST_WORD}))
            cur_err = 1'b1;
        if (!cur_store && (cur_funct3 inside {3'b011, 3'b110, 3'b111})) cur_err = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        store_d  = store_q;
        stall_o  = 1'b0;
        case (state_q)
            DMEM_IDLE: begin
                if (req) begin
                    stall_o  = 1'b1;
                    addr_d   = mem_addr_i;
                    wdata_d  = mem_data_i;
                    funct3_d = funct3_i;
                    store_d  = wmem_en_i;
                    cnt_d    = CNT_INIT;
                    state_d  = (WAIT_CYCLES == 0) ? DMEM_DONE : DMEM_WAIT;
                end
            end
            DMEM_WAIT: begin
                stall_o = 1'b1;
                if (cnt_q == 4'd0) state_d = DMEM_DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            DMEM_DONE: state_d = DMEM_IDLE;
            default:   state_d = DMEM_IDLE;
        endcase
    end

    always_comb begin
        enter_done = (state_d == DMEM_DONE) && !rst;
        bank_we    = (enter_done && cur_store && !cur_err) ? lane_enables(cur_funct3, cur_addr[1:0]) : 4'b0000;
        bank_re    = enter_done && !cur_store && !cur_err;
        rvalid_d   = bank_re;
        err_d      = enter_done && cur_err;
        case (cur_funct3[1:0])
            2'b00:   bank_wdata = {4{cur_wdata[7:0]}};
            2'b01:   bank_wdata = {2{cur_wdata[15:0]}};
            default: bank_wdata = cur_wdata;
        endcase
    end

    dmem_bank #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk     (clk),
        .re_i    (bank_re),
        .we_i    (bank_we),
        .idx_i   (cur_addr[IDX_W+1:2]),
        .wdata_i (bank_wdata),
        .rdata_o (bank_rdata)
    );

    // The bank output register doubles as the load-data register while in DONE;
    // rdata_q keeps the result afterwards.
    always_comb begin
        rdata_o = rdata_q;
        if (state_q == DMEM_DONE) begin
            if (err_q)         rdata_o = ZERO_WORD;
            else if (rvalid_q) rdata_o = (bank_rdata >> {addr_q[1:0], 3'b000}) & size_mask(funct3_q);
        end
        rdata_d = rdata_o;
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DMEM_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= ZERO_WORD;
            funct3_q <= 3'b000;
            store_q  <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= ZERO_WORD;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            store_q  <= store_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench: two responders (0 and 1 wait states) against a byte-array model.
module tb_dmem_resp;

    localparam int DEPTH = 64;
    localparam int LIMIT = 4 * DEPTH;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst, wen, ren, stall, rvalid, err;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [2:0]  f3 [2];

    dmem_resp #(.ADDR_WIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst[0]), .wmem_en_i(wen[0]), .rmem_en_i(ren[0]),
        .mem_addr_i(addr[0]), .mem_data_i(wdata[0]), .funct3_i(f3[0]),
        .rdata_o(rdata[0]), .rvalid_o(rvalid[0]), .stall_o(stall[0]), .err_o(err[0]));

    dmem_resp #(.ADDR_WIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst[1]), .wmem_en_i(wen[1]), .rmem_en_i(ren[1]),
        .mem_addr_i(addr[1]), .mem_data_i(wdata[1]), .funct3_i(f3[1]),
        .rdata_o(rdata[1]), .rvalid_o(rvalid[1]), .stall_o(stall[1]), .err_o(err[1]));

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  mdl_mem [2][LIMIT];
    logic [31:0] mdl_rd [2];

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  f;
        logic [31:0] rd;
        logic        rv;
        logic        er;
    } vec_t;
    vec_t vt [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_access(input int w, input logic we, input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] f, output logic [31:0] erd, output logic erv, output logic eer);
        int size;
        logic [31:0] v;
        size = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
        eer = 1'b0;
        erv = 1'b0;
        if (we && f > 3'd2) eer = 1'b1;
        if (!we && (f == 3'd3 || f == 3'd6 || f == 3'd7)) eer = 1'b1;
        if (a >= 32'(LIMIT)) eer = 1'b1;
        if (size == 2 && a[0]) eer = 1'b1;
        if (size == 4 && a[1:0] != 2'b00) eer = 1'b1;
        if (eer) mdl_rd[w] = 32'h0;
        else if (we) begin
            for (int i = 0; i < size; i++) mdl_mem[w][int'(a) + i] = d[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(mdl_mem[w][int'(a) + i]) << (8 * i));
            mdl_rd[w] = v;
            erv = 1'b1;
        end
        erd = mdl_rd[w];
    endtask

    task automatic run_access(input int w, input logic we, input logic re, input logic [31:0] a,
                              input logic [31:0] d, input logic [2:0] f,
                              output logic [31:0] rd, output logic rv, output logic er,
                              output int st, output logic busy_after);
        @(posedge clk); #1;
        wen[w] = we; ren[w] = re; addr[w] = a; wdata[w] = d; f3[w] = f;
        st = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall[w]) st++;
            else break;
        end
        rd = rdata[w]; rv = rvalid[w]; er = err[w];
        @(posedge clk); #1;
        wen[w] = 1'b0; ren[w] = 1'b0;
        @(negedge clk);
        busy_after = stall[w] | rvalid[w] | err[w];
    endtask

    task automatic check_access(input int w, input logic we, input logic re, input logic [31:0] a,
                                input logic [31:0] d, input logic [2:0] f, input string tag);
        logic [31:0] rd, erd;
        logic rv, er, erv, eer, busy;
        int st;
        run_access(w, we, re, a, d, f, rd, rv, er, st, busy);
        model_access(w, we, a, d, f, erd, erv, eer);
        chk($sformatf("%s stall_cycles", tag), 32'(st), 32'(w + 1));
        chk($sformatf("%s rdata", tag), rd, erd);
        chk($sformatf("%s rvalid", tag), 32'(rv), 32'(erv));
        chk($sformatf("%s err", tag), 32'(er), 32'(eer));
        chk($sformatf("%s idle_after", tag), 32'(busy), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, erd, a, d;
        logic rv, er, erv, eer, busy, we, re;
        int st, k;

        vt[0]  = '{1'b1, 1'b0, 32'h10,  32'hDEADBEEF, 3'b010, 32'h00000000, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 1'b1, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 32'h20,  32'hAABBCCDD, 3'b010, 32'hDEADBEEF, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 32'h21,  32'hFFFFFF12, 3'b000, 32'hDEADBEEF, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 32'h20,  32'h0,        3'b010, 32'hAABB12DD, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 32'h21,  32'h0,        3'b000, 32'h00000012, 1'b1, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 32'h32,  32'h1234BEEF, 3'b001, 32'h00000012, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 32'h30,  32'h0,        3'b010, 32'hBEEF0000, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 32'h13,  32'h0,        3'b001, 32'h00000000, 1'b0, 1'b1};
        vt[9]  = '{1'b1, 1'b0, 32'h06,  32'h11111111, 3'b010, 32'h00000000, 1'b0, 1'b1};
        vt[10] = '{1'b0, 1'b1, 32'h04,  32'h0,        3'b010, 32'h00000000, 1'b1, 1'b0};
        vt[11] = '{1'b0, 1'b1, 32'h23,  32'h0,        3'b100, 32'h000000AA, 1'b1, 1'b0};
        vt[12] = '{1'b0, 1'b1, 32'h22,  32'h0,        3'b101, 32'h0000AABB, 1'b1, 1'b0};
        vt[13] = '{1'b0, 1'b1, 32'h12,  32'h0,        3'b001, 32'h0000DEAD, 1'b1, 1'b0};
        vt[14] = '{1'b0, 1'b1, 32'h100, 32'h0,        3'b010, 32'h00000000, 1'b0, 1'b1};
        vt[15] = '{1'b0, 1'b1, 32'hFC,  32'h0,        3'b010, 32'h00000000, 1'b1, 1'b0};
        vt[16] = '{1'b0, 1'b1, 32'h10,  32'h0,        3'b011, 32'h00000000, 1'b0, 1'b1};
        vt[17] = '{1'b1, 1'b0, 32'h10,  32'h77777777, 3'b100, 32'h00000000, 1'b0, 1'b1};
        vt[18] = '{1'b0, 1'b1, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 1'b1, 1'b0};

        rst = 2'b11; wen = 2'b00; ren = 2'b00;
        for (int w = 0; w < 2; w++) begin
            addr[w] = 32'h0; wdata[w] = 32'h0; f3[w] = 3'b000; mdl_rd[w] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            chk($sformatf("reset%0d rdata", w), rdata[w], 32'h0);
            chk($sformatf("reset%0d rvalid", w), 32'(rvalid[w]), 32'h0);
            chk($sformatf("reset%0d err", w), 32'(err[w]), 32'h0);
            chk($sformatf("reset%0d stall", w), 32'(stall[w]), 32'h0);
        end
        @(posedge clk); #1;
        rst = 2'b00;

        for (int w = 0; w < 2; w++)
            for (int i = 0; i < DEPTH; i++) begin
                run_access(w, 1'b1, 1'b0, 32'(4 * i), 32'h0, 3'b010, rd, rv, er, st, busy);
                model_access(w, 1'b1, 32'(4 * i), 32'h0, 3'b010, erd, erv, eer);
            end

        for (int i = 0; i < 19; i++) begin
            run_access(1, vt[i].we, vt[i].re, vt[i].a, vt[i].d, vt[i].f, rd, rv, er, st, busy);
            model_access(1, vt[i].we, vt[i].a, vt[i].d, vt[i].f, erd, erv, eer);
            chk($sformatf("vec%0d stall_cycles", i), 32'(st), 32'd2);
            chk($sformatf("vec%0d rdata", i), rd, vt[i].rd);
            chk($sformatf("vec%0d rvalid", i), 32'(rv), 32'(vt[i].rv));
            chk($sformatf("vec%0d err", i), 32'(er), 32'(vt[i].er));
            chk($sformatf("vec%0d idle_after", i), 32'(busy), 32'h0);
        end

        // both enables high: treated as a store, one stall cycle with no wait states
        check_access(0, 1'b1, 1'b1, 32'h40, 32'h55, 3'b010, "dual_store");
        run_access(0, 1'b0, 1'b1, 32'h40, 32'h0, 3'b010, rd, rv, er, st, busy);
        model_access(0, 1'b0, 32'h40, 32'h0, 3'b010, erd, erv, eer);
        chk("dual_load rdata", rd, 32'h55);
        chk("dual_load rvalid", 32'(rv), 32'h1);
        chk("dual_load stall_cycles", 32'(st), 32'd1);

        for (int n = 0; n < 230; n++) begin
            k = (n < 150) ? 1 : 0;
            case ($urandom_range(0, 2))
                0:       begin we = 1'b1; re = 1'b0; end
                1:       begin we = 1'b0; re = 1'b1; end
                default: begin we = 1'b1; re = 1'b1; end
            endcase
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(0, LIMIT + 15));
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            d = $urandom;
            check_access(k, we, re, a, d, 3'($urandom_range(0, 7)), $sformatf("rand%0d", n));
        end

        // reset during WAIT aborts a pending store without any pulse
        check_access(1, 1'b1, 1'b0, 32'h50, 32'h13572468, 3'b010, "pre_old");
        check_access(1, 1'b1, 1'b0, 32'h58, 32'hCAFEF00D, 3'b010, "pre_st");
        check_access(1, 1'b0, 1'b1, 32'h58, 32'h0, 3'b010, "pre_ld");
        @(posedge clk); #1;
        wen[1] = 1'b1; addr[1] = 32'h50; wdata[1] = 32'h99; f3[1] = 3'b010;
        @(negedge clk);
        chk("abort stall_idle", 32'(stall[1]), 32'h1);
        @(posedge clk); #1;
        rst[1] = 1'b1;
        @(negedge clk);
        chk("abort stall_wait", 32'(stall[1]), 32'h1);
        @(posedge clk); #1;
        rst[1] = 1'b0; wen[1] = 1'b0;
        @(negedge clk);
        chk("abort rdata", rdata[1], 32'h0);
        chk("abort rvalid", 32'(rvalid[1]), 32'h0);
        chk("abort err", 32'(err[1]), 32'h0);
        chk("abort stall", 32'(stall[1]), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("abort quiet%0d", i), 32'({rvalid[1], err[1]}), 32'h0);
        end
        mdl_rd[1] = 32'h0;
        run_access(1, 1'b0, 1'b1, 32'h50, 32'h0, 3'b010, rd, rv, er, st, busy);
        chk("abort old_value", rd, 32'h13572468);
        chk("abort old_rvalid", 32'(rv), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
